// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: Gray-code state values,
// direction encoding and the transition classifier used by the decoder.
package quad_pkg;

    // Encoder states as {A,B}; forward rotation walks 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_01 = 2'b01;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        FWD     = 2'd1,
        REV     = 2'd2,
        ILLEGAL = 2'd3
    } trans_e;

    // Classify the move from prev to cur; a change of both channels at once is illegal
    function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_e t;
        logic [1:0] fwdNext;
        logic [1:0] revNext;
        fwdNext = ST_00;
        revNext = ST_00;
        case (prev)
            ST_00:   begin fwdNext = ST_10; revNext = ST_01; end
            ST_10:   begin fwdNext = ST_11; revNext = ST_00; end
            ST_11:   begin fwdNext = ST_01; revNext = ST_10; end
            default: begin fwdNext = ST_00; revNext = ST_11; end
        endcase
        if (cur == prev) begin
            t = NONE;
        end else if (cur == fwdNext) begin
            t = FWD;
        end else if (cur == revNext) begin
            t = REV;
        end else begin
            t = ILLEGAL;
        end
        return t;
    endfunction

endpackage

// File: rtl/step_period_timer.sv
// Saturating CE-tick counter measuring the interval between valid encoder steps.
// A restart (illegal transition) discards the measurement so the next step only
// re-arms the timer and the one after it reports a fresh interval.
module step_period_timer #(
    parameter int PER_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 synch_reset,
    input  logic                 CE,
    input  logic                 step_i,
    input  logic                 restart_i,
    output logic [PER_WIDTH-1:0] step_period,
    output logic                 period_valid,
    output logic                 stalled
);

    localparam logic [PER_WIDTH-1:0] CNT_MAX = '1;

    logic [PER_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [PER_WIDTH-1:0] step_period_q, step_period_d;
    logic [PER_WIDTH-1:0] cnt_inc;
    logic                 first_seen_q, first_seen_d;
    logic                 period_valid_q, period_valid_d;

    assign cnt_inc = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 1'b1;

    // Next-state: count idle ticks, capture the interval on a step, drop it on a restart
    always_comb begin
        period_cnt_d   = cnt_inc;
        first_seen_d   = first_seen_q;
        step_period_d  = step_period_q;
        period_valid_d = period_valid_q;
        if (restart_i) begin
            period_cnt_d   = '0;
            first_seen_d   = 1'b0;
            period_valid_d = 1'b0;
        end else if (step_i) begin
            if (first_seen_q) begin
                step_period_d  = cnt_inc;
                period_valid_d = 1'b1;
            end
            first_seen_d = 1'b1;
            period_cnt_d = '0;
        end
    end

    // State only moves on CE; reset is honoured only on a CE cycle
    always_ff @(posedge clk) begin
        if (CE) begin
            if (synch_reset) begin
                period_cnt_q   <= '0;
                first_seen_q   <= 1'b0;
                step_period_q  <= '0;
                period_valid_q <= 1'b0;
            end else begin
                period_cnt_q   <= period_cnt_d;
                first_seen_q   <= first_seen_d;
                step_period_q  <= step_period_d;
                period_valid_q <= period_valid_d;
            end
        end
    end

    assign step_period  = step_period_q;
    assign period_valid = period_valid_q;
    assign stalled      = (period_cnt_q == CNT_MAX);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder for the pendulum encoder: wrapping signed position,
// direction, one-clk step pulse, sticky illegal-transition flag and step period.
// Optional index zeroing is enabled by defining QUAD_INDEX_EN (adds idx_in).
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int POS_WIDTH = 16,
    parameter int PER_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 synch_reset,
    input  logic                 CE,
    input  logic                 a_in,
    input  logic                 b_in,
`ifdef QUAD_INDEX_EN
    input  logic                 idx_in,
`endif
    output logic [POS_WIDTH-1:0] position,
    output logic                 dir,
    output logic                 step,
    output logic [PER_WIDTH-1:0] step_period,
    output logic                 period_valid,
    output logic                 stalled,
    output logic                 err
);

    logic [1:0]           cur;
    logic [1:0]           prev_state_q;
    logic [POS_WIDTH-1:0] position_q, position_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic                 err_q, err_d;
    trans_e               trans;
    logic                 valid_step;
    logic                 illegal;

    assign cur        = {a_in, b_in};
    assign trans      = classify(prev_state_q, cur);
    assign valid_step = (trans == FWD) || (trans == REV);
    assign illegal    = (trans == ILLEGAL);

`ifdef QUAD_INDEX_EN
    logic idx_q;
`endif

    // Next-state: apply the decoded step to position/dir, latch illegal moves into err
    always_comb begin
        position_d = position_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        err_d      = err_q;
        case (trans)
            FWD: begin
                position_d = position_q + 1'b1;
                dir_d      = DIR_FWD;
                step_d     = 1'b1;
            end
            REV: begin
                position_d = position_q - 1'b1;
                dir_d      = DIR_REV;
                step_d     = 1'b1;
            end
            ILLEGAL: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
`ifdef QUAD_INDEX_EN
        if (idx_in && !idx_q) begin
            position_d = '0;
        end
`endif
    end

    // Registers advance on CE; the step pulse is cleared on every other edge
    always_ff @(posedge clk) begin
        if (CE) begin
            prev_state_q <= cur;
            if (synch_reset) begin
                position_q <= '0;
                dir_q      <= 1'b0;
                step_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                position_q <= position_d;
                dir_q      <= dir_d;
                step_q     <= step_d;
                err_q      <= err_d;
            end
        end else begin
            step_q <= 1'b0;
        end
    end

`ifdef QUAD_INDEX_EN
    // Previous index sample for rising-edge detection
    always_ff @(posedge clk) begin
        if (CE) begin
            if (synch_reset) begin
                idx_q <= 1'b0;
            end else begin
                idx_q <= idx_in;
            end
        end
    end
`endif

    step_period_timer #(
        .PER_WIDTH (PER_WIDTH)
    ) u_timer (
        .clk          (clk),
        .synch_reset  (synch_reset),
        .CE           (CE),
        .step_i       (valid_step),
        .restart_i    (illegal),
        .step_period  (step_period),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    assign position = position_q;
    assign dir      = dir_q;
    assign step     = step_q;
    assign err      = err_q;

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Consumes two debounced channels (A, B) from a pair of upstream inertial filters on the pendulum encoder. Both are synchronous to clk and advanced on the same CE.
- Decodes Gray-code transitions into a signed wrapping position, a direction bit and a one-clock step pulse.
- Measures the CE-tick interval between successive steps, for the speed/period logic downstream.
- Flags illegal double transitions.

Parameters:
- POS_WIDTH, 16, width of the position counter (two's complement, wraps).
- PER_WIDTH, 16, width of the step-period counter (unsigned, saturating).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- synch_reset  input  1  synchronous, active-high reset; effective only when CE=1.
- CE  input  1  clock enable; the same enable that drives the upstream filters.
- a_in  input  1  filtered channel A.
- b_in  input  1  filtered channel B.
- position  output  POS_WIDTH  signed position count.
- dir  output  1  direction of the last valid step; 1 = forward.
- step  output  1  one-clk pulse per valid step.
- step_period  output  PER_WIDTH  CE ticks between the last two valid steps.
- period_valid  output  1  step_period holds a real step-to-step interval.
- stalled  output  1  the period counter is saturated.
- err  output  1  sticky flag for an illegal transition.

Behaviour:
- Nothing updates when CE=0, except that step is forced to 0 on every clk edge.
- Reset takes priority over everything else when CE=1 and synch_reset=1:
  - prev_state <= {a_in, b_in};
  - position=0, dir=0, step=0, step_period=0, period_valid=0, err=0, period_cnt=0, first_seen=0;
  - stalled is combinational and therefore 0.
- Each CE cycle, cur = {a_in, b_in} is compared with prev_state, then prev_state <= cur.
- State FSM has 4 states, encoded {A,B}.
  - Forward order is 00->10->11->01->00 (A leads B).
  - Reverse order is the opposite sequence.
- No change: position holds; period_cnt <= sat(period_cnt+1).
- Forward step: position+1 (wraps from max positive to min negative), dir=1, step=1.
- Reverse step: position-1 (wraps from min to max), dir=0, step=1.
- Illegal transition (00<->11 or 01<->10):
  - err <= 1 (sticky until reset);
  - position and dir hold, no step pulse;
  - period_valid <= 0, first_seen <= 0, period_cnt <= 0.
- Period measurement on each valid step:
  - If first_seen=1: step_period <= sat(period_cnt+1) and period_valid <= 1.
  - Always: first_seen <= 1 and period_cnt <= 0.
  - Steps on consecutive CE cycles therefore give step_period=1.
- sat(x) clamps to 2^PER_WIDTH-1.
- stalled = (period_cnt == 2^PER_WIDTH-1). It clears on the next valid step.
- Latency: all outputs are registered and reflect the CE sample taken on the same clk edge; step is high for exactly one clk cycle.
- A direction reversal is a normal step in the opposite direction. The interval is still measured.

Optional Feature:
- Macro QUAD_INDEX_EN.
- When defined:
  - add port idx_in (input, 1, filtered index channel);
  - on a CE cycle where idx_in is 1 and the registered previous idx_in is 0, position <= 0, overriding any ±1 from that cycle;
  - step and dir still update normally;
  - the registered idx_in is cleared by reset.
- When undefined: no idx_in port and no index logic; position is changed only by steps and reset.

Decomposition:
- Package quad_pkg holds:
  - state encoding constants (ST_00, ST_10, ST_11, ST_01);
  - direction constants (DIR_FWD=1, DIR_REV=0);
  - a transition-classify function returning NONE, FWD, REV or ILLEGAL.
- One sub-module, step_period_timer: the saturating CE-tick counter with first_seen, step_period, period_valid and stalled. The decoder drives its step and restart inputs.

Test Plan:
- Reset with a=1, b=1, then hold for 5 CE -> position=0, err=0, step never asserted, period_cnt=5.
- Forward sequence 00,10,11,01,00, one transition every 4 CE -> position=4, dir=1, 4 step pulses each 1 clk wide, period_valid=1, step_period=4.
- Set POS_WIDTH=4 and drive from position 7 one forward step -> position=-8. Then one reverse step -> position=7, dir=0.
- From state 00 drive 11 -> err=1, position unchanged, period_valid=0. The next valid step gives no period update; the one after reports the correct interval.
- With PER_WIDTH=4, no transitions for 20 CE after a step -> stalled=1 from the 15th CE onward. The next step gives step_period=15 and stalled=0.
- QUAD_INDEX_EN defined: position=37, then an idx_in rising edge coincides with a forward step -> position=0, step=1, dir=1.
